// File: rtl/vga_sync_decoder_if.sv
// Observed VGA pins, probe setup and recovered timing for the vga_sync_decoder loop-back monitor.
// The master side drives the pins and the probe point. The slave side is the decoder.
interface vga_sync_decoder_if;
  logic        VGA_HS;
  logic        VGA_VS;
  logic [7:0]  VGA_R;
  logic [7:0]  VGA_G;
  logic [7:0]  VGA_B;
  logic [10:0] probeX;
  logic [10:0] probeY;
  logic [10:0] XPos;
  logic [10:0] YPos;
  logic        pixelValid;
  logic [23:0] pixelRGB;
  logic        frameStart;
  logic        locked;
  logic        hErr;
  logic        vErr;
  logic [15:0] frameCount;
  logic [23:0] probeRGB;
  logic        probeValid;

  modport master (
    output VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B, probeX, probeY,
    input  XPos, YPos, pixelValid, pixelRGB, frameStart, locked, hErr, vErr,
           frameCount, probeRGB, probeValid
  );

  modport slave (
    input  VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B, probeX, probeY,
    output XPos, YPos, pixelValid, pixelRGB, frameStart, locked, hErr, vErr,
           frameCount, probeRGB, probeValid
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates, frame boundaries and timing lock from observed VGA syncs and colour.
// The probe capture is built only when VGA_SYNC_DECODER_PROBE_EN is defined.
//
// state  | meaning
// SEARCH | no timing reference, waiting for a VS leading edge
// ALIGN  | frame counter resynced, waiting for one clean full frame
// TRACK  | locked, pixelValid allowed, frameCount advancing
module vga_sync_decoder #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FRONT  = 48,
  parameter int H_SYNC   = 112,
  parameter int H_BACK   = 248,
  parameter int V_ACTIVE = 1024,
  parameter int V_FRONT  = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 38,
  parameter bit SYNC_POL = 1'b1
) (
  input logic               pixelClock,
  input logic               resetN,
  vga_sync_decoder_if.slave vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int H_START = H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int V_START = V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ST    = 11'(H_START);
  localparam logic [10:0] V_ST    = 11'(V_START);
  localparam logic [11:0] H_END   = 12'(H_START + H_ACTIVE);
  localparam logic [11:0] V_END   = 12'(V_START + V_ACTIVE);
  localparam logic [10:0] CNT_MAX = 11'h7FF;

  typedef enum logic [1:0] {SEARCH, ALIGN, TRACK} state_t;

  state_t      state, state_nxt;
  logic        s1_hs, s1_vs, s2_hs, s2_vs;
  logic [23:0] s1_rgb;
  logic [10:0] h_count, v_count, h_nxt, v_nxt;
  logic        vs_pending, vs_pending_nxt;
  logic        synced, synced_nxt;
  logic        hs_edge, vs_edge, frame_now, h_err_now, v_err_now, h_act, v_act;

  assign hs_edge = (s1_hs == SYNC_POL) && (s2_hs != SYNC_POL);
  assign vs_edge = (s1_vs == SYNC_POL) && (s2_vs != SYNC_POL);

  // h_nxt/v_nxt are the coordinates of the pixel currently held in S1
  always_comb begin
    h_nxt          = (h_count == CNT_MAX) ? CNT_MAX : h_count + 11'd1;
    v_nxt          = v_count;
    vs_pending_nxt = vs_pending;
    frame_now      = 1'b0;
    if (hs_edge) begin
      h_nxt = '0;
      if (vs_pending || vs_edge) begin
        frame_now      = 1'b1;
        v_nxt          = '0;
        vs_pending_nxt = 1'b0;
      end else begin
        v_nxt = (v_count == CNT_MAX) ? CNT_MAX : v_count + 11'd1;
      end
    end else if (vs_edge) begin
      vs_pending_nxt = 1'b1;
    end
    h_err_now = hs_edge && (state != SEARCH) && (h_count != H_LAST);
    v_err_now = frame_now && (state == TRACK) && (v_count != V_LAST);
    h_act     = (h_nxt >= H_ST) && ({1'b0, h_nxt} < H_END);
    v_act     = (v_nxt >= V_ST) && ({1'b0, v_nxt} < V_END);
  end

  always_comb begin
    state_nxt  = state;
    synced_nxt = synced;
    case (state)
      SEARCH: begin
        synced_nxt = 1'b0;
        if (vs_edge) state_nxt = ALIGN;
      end
      ALIGN: begin
        if (h_err_now) begin
          state_nxt = SEARCH;
        end else if (frame_now) begin
          synced_nxt = 1'b1;
          if (synced && (v_count == V_LAST)) state_nxt = TRACK;
        end
      end
      TRACK: begin
        if (h_err_now || v_err_now) state_nxt = SEARCH;
      end
      default: state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge pixelClock) begin
    if (!resetN) begin
      s1_hs      <= ~SYNC_POL;
      s1_vs      <= ~SYNC_POL;
      s2_hs      <= ~SYNC_POL;
      s2_vs      <= ~SYNC_POL;
      s1_rgb     <= '0;
      h_count    <= '0;
      v_count    <= '0;
      vs_pending <= 1'b0;
      synced     <= 1'b0;
      state      <= SEARCH;
    end else begin
      s1_hs      <= vga.VGA_HS;
      s1_vs      <= vga.VGA_VS;
      s2_hs      <= s1_hs;
      s2_vs      <= s1_vs;
      s1_rgb     <= {vga.VGA_R, vga.VGA_G, vga.VGA_B};
      h_count    <= h_nxt;
      v_count    <= v_nxt;
      vs_pending <= vs_pending_nxt;
      synced     <= synced_nxt;
      state      <= state_nxt;
    end
  end

  always_ff @(posedge pixelClock) begin
    if (!resetN) begin
      vga.XPos       <= '0;
      vga.YPos       <= '0;
      vga.pixelValid <= 1'b0;
      vga.pixelRGB   <= '0;
      vga.frameStart <= 1'b0;
      vga.hErr       <= 1'b0;
      vga.vErr       <= 1'b0;
      vga.locked     <= 1'b0;
      vga.frameCount <= '0;
    end else begin
      vga.XPos       <= (h_act && v_act) ? (h_nxt - H_ST) : '0;
      vga.YPos       <= (h_act && v_act) ? (v_nxt - V_ST) : '0;
      vga.pixelValid <= h_act && v_act && (state_nxt == TRACK);
      vga.pixelRGB   <= s1_rgb;
      vga.frameStart <= frame_now;
      vga.hErr       <= h_err_now;
      vga.vErr       <= v_err_now;
      vga.locked     <= (state_nxt == TRACK);
      if (frame_now && (state == TRACK) && !h_err_now && !v_err_now)
        vga.frameCount <= vga.frameCount + 16'd1;
    end
  end

`ifdef VGA_SYNC_DECODER_PROBE_EN
  logic [10:0] s1_probe_x, s1_probe_y, probe_x_lat, probe_y_lat;

  always_ff @(posedge pixelClock) begin
    if (!resetN) begin
      s1_probe_x     <= '0;
      s1_probe_y     <= '0;
      probe_x_lat    <= '0;
      probe_y_lat    <= '0;
      vga.probeRGB   <= '0;
      vga.probeValid <= 1'b0;
    end else begin
      s1_probe_x     <= vga.probeX;
      s1_probe_y     <= vga.probeY;
      vga.probeValid <= 1'b0;
      if (frame_now) begin
        probe_x_lat <= s1_probe_x;
        probe_y_lat <= s1_probe_y;
      end
      if (vga.pixelValid && (vga.XPos == probe_x_lat) && (vga.YPos == probe_y_lat)) begin
        vga.probeRGB   <= vga.pixelRGB;
        vga.probeValid <= 1'b1;
      end
    end
  end
`else
  logic unused_probe;
  assign unused_probe   = ^{vga.probeX, vga.probeY};
  assign vga.probeRGB   = '0;
  assign vga.probeValid = 1'b0;
`endif

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart of the VGA timing generator: watches `VGA_HS`, `VGA_VS` and the 24-bit colour bus on the pixel clock and recovers pixel coordinates, frame boundaries and timing lock. It also captures the colour at one programmable probe coordinate per frame. It sits as a loop-back monitor beside the VGA output path and lets benches and on-chip self-test check what was actually driven to the screen.

## Interface
Parameters (defaults are 1280x1024@60):
- `H_ACTIVE`, 1280, visible pixels per line
- `H_FRONT`, 48, horizontal front porch in clocks
- `H_SYNC`, 112, HS pulse width in clocks
- `H_BACK`, 248, horizontal back porch in clocks
- `V_ACTIVE`, 1024, visible lines per frame
- `V_FRONT`, 1, vertical front porch in lines
- `V_SYNC`, 3, VS pulse width in lines
- `V_BACK`, 38, vertical back porch in lines
- `SYNC_POL`, 1, asserted level of HS/VS (1 = positive)

Ports:
- `pixelClock`  in  1  pixel clock; single clock domain
- `resetN`  in  1  reset; synchronous, active-low
- `VGA_HS`, `VGA_VS`  in  1 each  observed syncs
- `VGA_R`, `VGA_G`, `VGA_B`  in  8 each  observed colour
- `probeX`, `probeY`  in  11 each  probe coordinate; sampled at frameStart
- `XPos`, `YPos`  out  11 each  recovered coordinate of `pixelRGB`
- `pixelValid`  out  1  high while `XPos`/`YPos` are in the active area and `locked`=1
- `pixelRGB`  out  24  {R,G,B} aligned with `XPos`/`YPos`
- `frameStart`  out  1  one-cycle pulse at line 0 of each frame
- `locked`  out  1  timing lock
- `hErr`, `vErr`  out  1 each  one-cycle pulse on a line-length or line-count violation
- `frameCount`  out  16  frames completed while locked; wraps
- `probeRGB`  out  24  colour captured at the probe point
- `probeValid`  out  1  one-cycle pulse when `probeRGB` updates

## Operation
- All inputs are registered once (stage S1). Edge detection compares S1 with a second register S2. An HS leading edge is S2 not asserted and S1 asserted, relative to `SYNC_POL`. VS uses the same rule.
- Derived constants: `H_TOTAL`=`H_ACTIVE`+`H_FRONT`+`H_SYNC`+`H_BACK`; `H_START`=`H_SYNC`+`H_BACK`. `V_TOTAL` and `V_START` are defined the same way.
- `hCount` (11 bits):
  - loads 0 on an HS leading edge, otherwise increments;
  - saturates at 2047.
- Line check: on each HS leading edge while in ALIGN or TRACK, if `hCount` is not `H_TOTAL`-1, pulse `hErr`.
- VS leading edge sets `vsPending`. `vCount` handling:
  - On the first HS leading edge in the same cycle or later with `vsPending`=1: `vCount` goes to 0, `vsPending` is cleared, and `frameStart` pulses.
  - On any other HS leading edge: `vCount` increments, saturating at 2047.
- Frame check: when `vCount` resets to 0 in TRACK, if the previous value was not `V_TOTAL`-1, pulse `vErr`.
- Coordinates: `XPos`=`hCount`-`H_START` and `YPos`=`vCount`-`V_START`. They are valid when `H_START`≤`hCount`<`H_START`+`H_ACTIVE` and the same condition holds vertically; otherwise `XPos`/`YPos` are 0.
- FSM states:
  - SEARCH: waits for a VS leading edge, then goes to ALIGN.
  - ALIGN: the frame resync occurs. Goes to TRACK when one full frame passes with no `hErr`/`vErr`.
  - TRACK: `locked`=1 and `frameCount` increments at each `frameStart`.
  - Any `hErr` or `vErr` returns the FSM to SEARCH and clears `locked` the next cycle. `frameCount` holds its value.
- Probe: `probeX`/`probeY` are latched at `frameStart`. When `pixelValid` is high and `XPos`/`YPos` equal the latched values, `probeRGB` loads `pixelRGB` and `probeValid` pulses. A probe point outside the active area never produces `probeValid`.
- Reset values: all outputs 0, FSM in SEARCH, `vsPending`=0, `hCount`=`vCount`=0.

## Timing
- Latency from an input colour sample to `pixelRGB`/`XPos`/`YPos`/`pixelValid`: 2 `pixelClock` cycles.
- `frameStart`, `hErr` and `vErr` appear 2 cycles after the causing HS edge at the pins.
- `probeRGB` and `probeValid` appear 1 cycle after the matching `pixelValid` beat, so 3 cycles from the pin.
- HS and VS leading edges in the same cycle count as one frame start. No extra line is counted.
- A missing HS makes `hCount` saturate. The next HS edge then flags `hErr`.
- Deasserting `resetN` mid-frame restarts the decoder in SEARCH. The first `frameStart` after reset is not checked for `vErr`.
- `probeX`/`probeY` changes mid-frame take effect at the next `frameStart`.

## Configuration
- `VGA_SYNC_DECODER_PROBE_EN`:
  - Defined: probe latch, comparator and `probeRGB`/`probeValid` logic are built.
  - Undefined: that logic is omitted, `probeRGB` is tied to 0 and `probeValid` to 0. All other behaviour is identical.

## Test plan
- Reset, then three ideal 1280x1024 frames, with colour = {x[7:0], y[7:0], 8'h5A} → `locked` rises after frame 2. `pixelRGB` matches `XPos`/`YPos` on every valid beat and `frameCount`=1 after frame 3.
- One line shortened to 1687 clocks → `hErr` pulses once, `locked` falls, then relocks after two good frames. `frameCount` holds during the outage.
- Frame with 1065 lines → `vErr` at the next `frameStart` and the decoder returns to SEARCH.
- `probeX`=0x4FF, `probeY`=0x3FF, pixel (1279,1023) driven 24'hC0FFEE → `probeValid` once per frame with `probeRGB`=24'hC0FFEE. With `probeX`=1280, no pulse.
- `resetN` low for 1 cycle mid-line 500 → all outputs 0 next cycle, then relock within two frames. Repeat the whole bench with `SYNC_POL`=0 and inverted syncs: results must be identical.
